// File: rtl/mmio_pkg.sv
// Shared definitions for the timer MMIO slice: base addresses, register offsets,
// CTRL bit indices, STATUS field positions and the timer_cmp FSM state type.
package mmio_pkg;

    localparam logic [63:0] TIMER_ADDR     = 64'hb000_0000;
    localparam logic [63:0] TIMER_CMP_BASE = 64'hb000_0008;

    // Register offsets from the timer_cmp base address.
    localparam logic [63:0] REG_MTIMECMP = 64'h00;
    localparam logic [63:0] REG_PERIOD   = 64'h08;
    localparam logic [63:0] REG_CTRL     = 64'h10;
    localparam logic [63:0] REG_STATUS   = 64'h18;

    // CTRL bit indices.
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IE       = 2;
    localparam int unsigned CTRL_W        = 3;

    // STATUS field positions.
    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_OVR_LSB     = 8;
    localparam int unsigned STATUS_OVR_W       = 8;
    localparam int unsigned STATUS_STATE_LSB   = 16;
    localparam int unsigned STATUS_STATE_W     = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StFired = 2'd2
    } cmp_state_e;

endpackage

// File: rtl/mmio_reg64.sv
// 64-bit MMIO register with per-byte write enables and a synchronous reset value.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   we, wmask, wdata software store (byte mask honoured)
//   ld, ld_data      hardware load (e.g. periodic reload)
//   q                current register value
// When ld and we coincide, the hardware load forms the base value and the bytes
// selected by wmask are then overwritten by software data.
module mmio_reg64 #(
    parameter logic [63:0] ResetVal = '0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic [7:0]  wmask,
    input  logic [63:0] wdata,
    input  logic        ld,
    input  logic [63:0] ld_data,
    output logic [63:0] q
);

    logic [63:0] q_q;
    logic [63:0] q_d;
    logic [63:0] base;

    always_comb begin
        base = ld ? ld_data : q_q;
        q_d  = base;
        for (int i = 0; i < 8; i++) begin
            if (we && wmask[i]) begin
                q_d[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= ResetVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/timer_cmp.sv
// Timer-compare and interrupt unit. Compares mtime against MTIMECMP, latches a
// pending flag, counts overruns and drives a level interrupt. Supports one-shot
// and periodic auto-reload.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   mtime                free-running 64-bit time from the timer block
//   ren, raddr, rdata    load port (rdata combinational, 0 when idle/unmapped)
//   wen, waddr, wdata,
//   wmask                store port with byte enables
//   irq                  level interrupt = pending & ie (registered)
module timer_cmp
    import mmio_pkg::*;
#(
    parameter logic [63:0] BASE = TIMER_CMP_BASE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] mtime,
    input  logic        ren,
    input  logic [63:0] raddr,
    output logic [63:0] rdata,
    input  logic        wen,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic        irq
);

    localparam logic [63:0] AddrCmp    = BASE + REG_MTIMECMP;
    localparam logic [63:0] AddrPeriod = BASE + REG_PERIOD;
    localparam logic [63:0] AddrCtrl   = BASE + REG_CTRL;
    localparam logic [63:0] AddrStatus = BASE + REG_STATUS;

    logic [63:0]       cmp_q;
    logic [63:0]       period_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic              pending_q;
    logic              pending_d;
    logic [7:0]        overrun_q;
    logic [7:0]        overrun_d;
    cmp_state_e        state_q;

    logic sel_cmp;
    logic sel_period;
    logic wr_cmp;
    logic wr_ctrl;
    logic w1c;
    logic hit;
    logic fire;
    logic reload;
    logic [63:0] status_rd;

    always_comb begin
        sel_cmp    = wen && (waddr == AddrCmp);
        sel_period = wen && (waddr == AddrPeriod);
        wr_cmp     = sel_cmp && (wmask != 8'h00);
        wr_ctrl    = wen && (waddr == AddrCtrl) && wmask[0];
        w1c        = wen && (waddr == AddrStatus) && wmask[0] && wdata[STATUS_PENDING_BIT];

        ctrl_d = wr_ctrl ? wdata[CTRL_W-1:0] : ctrl_q;

        // Compare uses the pre-write MTIMECMP; a same-cycle en=0 write suppresses the hit.
        hit    = (mtime >= cmp_q);
        fire   = (state_q == StArmed) && hit && ctrl_d[CTRL_EN];
        reload = fire && ctrl_q[CTRL_PERIODIC] && (period_q != 64'd0);

        // Set beats W1C; W1C still clears overrun in that cycle.
        pending_d = fire | (pending_q & ~w1c);
        overrun_d = overrun_q;
        if (w1c) begin
            overrun_d = 8'd0;
        end else if (fire && pending_q && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    mmio_reg64 #(
        .ResetVal ('1)
    ) u_mtimecmp (
        .clk     (clk),
        .rstn    (rstn),
        .we      (sel_cmp),
        .wmask   (wmask),
        .wdata   (wdata),
        .ld      (reload),
        .ld_data (cmp_q + period_q),
        .q       (cmp_q)
    );

    mmio_reg64 #(
        .ResetVal ('0)
    ) u_period (
        .clk     (clk),
        .rstn    (rstn),
        .we      (sel_period),
        .wmask   (wmask),
        .wdata   (wdata),
        .ld      (1'b0),
        .ld_data (64'd0),
        .q       (period_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            ctrl_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 8'd0;
            irq       <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq       <= pending_d & ctrl_d[CTRL_IE];
            if (!ctrl_d[CTRL_EN]) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle:  state_q <= StArmed;
                    // A same-cycle MTIMECMP write re-arms, so only fall to FIRED without one.
                    StArmed: if (fire && !reload && !wr_cmp) state_q <= StFired;
                    StFired: if (wr_cmp) state_q <= StArmed;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        status_rd = 64'd0;
        status_rd[STATUS_PENDING_BIT] = pending_q;
        status_rd[STATUS_OVR_LSB +: STATUS_OVR_W] = overrun_q;
        status_rd[STATUS_STATE_LSB +: STATUS_STATE_W] = state_q;

        rdata = 64'd0;
        if (ren) begin
            if (raddr == AddrCmp) begin
                rdata = cmp_q;
            end else if (raddr == AddrPeriod) begin
                rdata = period_q;
            end else if (raddr == AddrCtrl) begin
                rdata = {{(64 - CTRL_W){1'b0}}, ctrl_q};
            end else if (raddr == AddrStatus) begin
                rdata = status_rd;
            end
        end
    end

endmodule
